// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: fetch defaults, NOP encoding, fetch FSM states and
// the opcode/funct constants consumed by the control decoder.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000; // sll $0,$0,0
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Fetch FSM: RUN fetches normally, HALTED is left only by reset.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Opcodes (instr[31:26]) understood by the control decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Function codes (instr[5:0]) for R-type instructions.
    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_ADD     = 6'h20;
    localparam logic [5:0] FUNCT_SUB     = 6'h22;

    // Force a fetch target onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with bubble/hold/load control and a count of
// instructions accepted into ID.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q,    valid_d;
    logic [31:0] count_q,    count_d;

    // Next-state: bubble beats hold, hold beats load; only a load counts.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (bubble) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0000_0000;
            valid_d    = 1'b0;
        end else if (hold) begin
            instr_d    = instr_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end else begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
            count_d    = count_q + 32'd1;
        end
    end

    // Register update with synchronous reset to a bubble and zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            count_q    <= 32'h0000_0000;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign id_instr    = instr_q;
    assign id_pc_plus4 = pc_plus4_q;
    assign id_valid    = valid_q;
    assign fetch_count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [5:0]  id_op_code,
    output logic [5:0]  id_funct,
    output logic        halted,
    output logic [31:0] fetch_count
);

    logic [31:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_plus4_s;
    logic         halt_entry_s;
    logic         ifid_bubble_s;
    logic         ifid_hold_s;

    assign pc_plus4_s = pc_q + PC_STEP;

    // Next PC, FSM transition and IF/ID control. A halt only counts when
    // the instruction in ID is real; once HALTED every input is ignored.
    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        halt_entry_s  = 1'b0;
        ifid_bubble_s = 1'b0;
        ifid_hold_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d = align_pc(redirect_pc);
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4_s;
                end
                if (halt && id_valid) begin
                    halt_entry_s = 1'b1;
                    state_d      = ST_HALTED;
                end else begin
                    state_d      = ST_RUN;
                end
                ifid_bubble_s = flush | redirect_valid | halt_entry_s;
                ifid_hold_s   = stall;
            end
            ST_HALTED: begin
                pc_d          = pc_q;
                state_d       = ST_HALTED;
                ifid_bubble_s = 1'b1;
                ifid_hold_s   = 1'b0;
            end
            default: begin
                pc_d          = pc_q;
                state_d       = ST_RUN;
                ifid_bubble_s = 1'b1;
                ifid_hold_s   = 1'b0;
            end
        endcase
    end

    // PC and FSM state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble      (ifid_bubble_s),
        .hold        (ifid_hold_s),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_plus4_s),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .fetch_count (fetch_count)
    );

    assign imem_addr  = pc_q;
    assign halted     = (state_q == ST_HALTED);
    assign id_op_code = id_instr[31:26];
    assign id_funct   = id_instr[5:0];

endmodule
